// File: rtl/iter_countdown_6bit.sv
// Loadable down-counter that sequences the iteration count of the multi-cycle
// multiply/divide datapath. It loads a count on start, steps down on en, and
// terminates itself, reporting the final iteration (last) and completion (done).
//
// state | meaning
// IDLE  | waiting for start, q holds its last value
// RUN   | counting down on en, busy high
// DONE  | one-cycle completion pulse, q = 0
module iter_countdown_6bit #(
  parameter int WIDTH = 6
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             abort_i,
  output logic [WIDTH-1:0] q_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             last_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;

  // State and count registers; clr wins over every other input.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= IDLE;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
    end
  end

  // Next-state and next-count: abort > start > en inside the states that honour them.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          q_d     = load_val_i;
          // A zero load still produces a single done pulse.
          state_d = (load_val_i == '0) ? DONE : RUN;
        end else if (state_q == DONE) begin
          q_d     = '0;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (en_i) begin
          // Terminal count at 1: the next step finishes instead of wrapping.
          if (q_q > WIDTH'(1)) begin
            q_d = q_q - WIDTH'(1);
          end else begin
            q_d     = '0;
            state_d = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        q_d     = '0;
      end
    endcase
  end

  // Status decodes straight off the state register, so busy/done are glitch-free.
  always_comb begin
    q_o    = q_q;
    busy_o = (state_q == RUN);
    done_o = (state_q == DONE);
    last_o = (state_q == RUN) && (q_q == WIDTH'(1));
  end

endmodule

// File: tb/tb_iter_countdown_6bit.sv
// Self-checking bench for iter_countdown_6bit: table vectors, corner sequences
// and randomized traffic against a behavioural model.
module tb_iter_countdown_6bit;

  logic       clk;
  logic       clr;
  logic       start;
  logic [5:0] load_val;
  logic       en;
  logic       abort;
  logic [5:0] q;
  logic       busy;
  logic       done;
  logic       last;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: remaining count plus "running" and "just finished" flags.
  int m_q    = 0;
  bit m_run  = 1'b0;
  bit m_fin  = 1'b0;

  iter_countdown_6bit #(.WIDTH(6)) dut (
    .clk_i      (clk),
    .clr_i      (clr),
    .start_i    (start),
    .load_val_i (load_val),
    .en_i       (en),
    .abort_i    (abort),
    .q_o        (q),
    .busy_o     (busy),
    .done_o     (done),
    .last_o     (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       clr;
    bit       start;
    bit [5:0] load;
    bit       en;
    bit       abort;
    int       exp_q;
    bit       exp_busy;
    bit       exp_done;
    bit       exp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit c, input bit s, input int l, input bit e, input bit a);
    clr      = c;
    start    = s;
    load_val = 6'(l);
    en       = e;
    abort    = a;
  endtask

  // Apply one edge of the specified rules to the model using the current inputs.
  task automatic model_step();
    if (clr) begin
      m_q = 0; m_run = 0; m_fin = 0;
    end else if (m_run) begin
      if (abort) begin
        m_run = 0;
      end else if (en) begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_run = 0;
          m_fin = 1;
        end
      end
    end else if (start) begin
      m_q   = int'(load_val);
      m_run = (m_q != 0);
      m_fin = (m_q == 0);
    end else begin
      if (m_fin) m_q = 0;
      m_fin = 0;
    end
  endtask

  // One clock: advance, sample 1 ns after the edge, compare against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("model_q", int'(q), m_q);
    chk("model_busy", int'(busy), int'(m_run));
    chk("model_done", int'(done), int'(m_fin));
    chk("model_last", int'(last), int'(m_run && m_q == 1));
  endtask

  task automatic add(input bit c, input bit s, input int l, input bit e, input bit a,
                     input int eq, input bit eb, input bit ed, input bit el);
    vec_t v;
    v.clr = c; v.start = s; v.load = 6'(l); v.en = e; v.abort = a;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed; v.exp_last = el;
    vecs.push_back(v);
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    bit got_done;

    drive(1, 1, 5, 0, 0);

    // Reset held with start/load 5, then idle.
    add(1, 1, 5, 0, 0, 0, 0, 0, 0);
    add(1, 1, 5, 0, 0, 0, 0, 0, 0);
    add(0, 0, 5, 0, 0, 0, 0, 0, 0);
    add(0, 0, 5, 1, 1, 0, 0, 0, 0);
    // Basic run of 4.
    add(0, 1, 4, 1, 0, 4, 1, 0, 0);
    add(0, 0, 0, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0);
    // Stall at q=2 for two cycles, mid-run start with 9 ignored.
    add(0, 1, 3, 1, 0, 3, 1, 0, 0);
    add(0, 0, 0, 1, 0, 2, 1, 0, 0);
    add(0, 0, 0, 0, 0, 2, 1, 0, 0);
    add(0, 1, 9, 0, 0, 2, 1, 0, 0);
    add(0, 0, 0, 1, 0, 1, 1, 0, 1);
    add(0, 0, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].clr, vecs[i].start, int'(vecs[i].load), vecs[i].en, vecs[i].abort);
      tick();
      chk($sformatf("vec%0d_q", i), int'(q), vecs[i].exp_q);
      chk($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].exp_done));
      chk($sformatf("vec%0d_last", i), int'(last), int'(vecs[i].exp_last));
    end

    // Zero load: one done pulse, busy never rises.
    drive(0, 1, 0, 1, 0);
    tick();
    chk("zero_done", int'(done), 1);
    chk("zero_busy", int'(busy), 0);
    chk("zero_q", int'(q), 0);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("zero_done_after", int'(done), 0);
    chk("zero_busy_after", int'(busy), 0);

    // Full-scale load of 63: 63 busy cycles then done, no wrap.
    drive(0, 1, 63, 1, 0);
    tick();
    chk("max_first_q", int'(q), 63);
    busy_cnt = busy ? 1 : 0;
    got_done = 1'b0;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 100 && !got_done; i++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) got_done = 1'b1;
    end
    chk("max_busy_cycles", busy_cnt, 63);
    chk("max_got_done", int'(got_done), 1);
    chk("max_done_q", int'(q), 0);

    // Back-to-back: new start during the done cycle, no idle gap.
    drive(0, 1, 1, 1, 0);
    tick();
    chk("b2b_first_q", int'(q), 1);
    drive(0, 0, 0, 1, 0);
    tick();
    chk("b2b_done", int'(done), 1);
    drive(0, 1, 2, 1, 0);
    tick();
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_q", int'(q), 2);
    drive(0, 0, 0, 0, 0);
    tick();
    chk("b2b_hold_busy", int'(busy), 1);

    // Abort at q=6 of a 10-run.
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 1, 10, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_pre_q", int'(q), 6);
    drive(0, 0, 0, 1, 1);
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_q", int'(q), 6);
    done_cnt = done ? 1 : 0;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_q_held", int'(q), 6);

    // Same run cut by clr instead; start alongside clr is discarded.
    drive(0, 1, 10, 1, 0);
    tick();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("clr_pre_q", int'(q), 6);
    drive(1, 1, 7, 1, 1);
    tick();
    chk("clr_q", int'(q), 0);
    chk("clr_busy", int'(busy), 0);
    done_cnt = done ? 1 : 0;
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) done_cnt++;
    end
    chk("clr_no_done", done_cnt, 0);
    chk("clr_stays_idle", int'(busy), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int l;
      l = ($urandom_range(0, 15) == 0) ? 63 : int'($urandom_range(0, 12));
      drive($urandom_range(0, 63) == 0,
            $urandom_range(0, 3) == 0,
            l,
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 23) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iter_countdown_6bit.md
# iter_countdown_6bit

Loadable 6-bit down-counter with start/busy/done handshake. It sequences the iteration count of the multi-cycle multiply/divide datapath: the controller loads an iteration count and steps the counter with `en`. The block then reports the final iteration (`last`) and completion (`done`) to that controller. It counts in the opposite direction to the free-running up-counter used elsewhere in MultDiv. Because it terminates itself, the datapath needs no external compare against a constant.

## Interface
- `WIDTH`, 6, counter width; all arithmetic is modulo 2^WIDTH.
- `clk` input 1: rising-edge clock; the only clock.
- `clr` input 1: reset, synchronous and active-high. Overrides all other inputs.
- `start` input 1: request to load `load_val` and begin counting. Accepted only in IDLE or DONE.
- `load_val` input WIDTH: number of iterations. Sampled only on an accepted `start`.
- `en` input 1: step enable. Honoured only in RUN.
- `abort` input 1: cancel a run. Honoured only in RUN.
- `q` output WIDTH: remaining iteration count, registered.
- `busy` output 1: high in RUN, registered.
- `done` output 1: high for exactly one cycle, in DONE only. Registered.
- `last` output 1: combinational, `busy & (q == 1)`. Flags the final iteration.

## Operation
- States are IDLE, RUN and DONE. `busy` = (state == RUN); `done` = (state == DONE).
- Input priority at each edge is `clr` > `abort` > `start` > `en`.
- `clr` high at an edge sets state to IDLE, `q` = 0, `busy` = 0, `done` = 0. This applies in any state, including mid-run.
- IDLE:
  - `start` with `load_val` ≠ 0: `q` ← `load_val`, go to RUN.
  - `start` with `load_val` = 0: `q` ← 0, go to DONE. A zero-length run still produces one `done` pulse.
  - Otherwise `q` holds.
  - `en` and `abort` are ignored.
- RUN:
  - `abort`: go to IDLE, `q` holds its current value, no `done` pulse.
  - `en` with `q` > 1: `q` ← `q` − 1, stay in RUN.
  - `en` with `q` = 1: `q` ← 0, go to DONE.
  - `en` low: hold state and `q`; stall cycles are unlimited.
  - `start` is ignored. No reload and no error.
- DONE: lasts exactly one cycle.
  - `start` is accepted as in IDLE (back-to-back runs), so the next state is RUN or DONE.
  - Otherwise go to IDLE with `q` = 0.
- `q` never wraps below 0 and never underflows. `q` = 0 is reachable only via `clr`, a completed run or a zero load.
- `load_val` = 63 is legal and gives a 63-iteration run.

## Timing
- Edge k means the k-th rising edge; "cycle k" is the interval after edge k.
- Reset values after any edge with `clr` = 1: `q` = 0, `busy` = 0, `done` = 0, `last` = 0.
- Start with `load_val` = N ≥ 1 and `en` held high:
  - `start` is sampled at edge 0.
  - `busy` is high in cycles 0..N−1, with `q` = N, N−1, …, 1.
  - `last` is high in cycle N−1 only.
  - `done` is high in cycle N; `busy` is 0 in that cycle.
- Each `en`-low cycle in RUN delays `done` by exactly one cycle.
- Start with `load_val` = 0 sampled at edge 0: `done` is high in cycle 0 and `busy` never rises.
- `abort` sampled at edge k in RUN: `busy` = 0 in cycle k, and `done` does not pulse.
- `start` sampled on the edge that leaves DONE: cycle k is RUN with `q` = new `load_val`. There is no idle gap.
- `clr` sampled together with `start` or `abort`: the block is in reset state and `load_val` is discarded.

## Test plan
- Reset: hold `clr` for 2 cycles with `start` = 1 and `load_val` = 5. Then `q` = 0, `busy` = 0, `done` = 0, and the block remains IDLE after `clr` falls until a new `start`.
- Basic run: `start` with `load_val` = 4 and `en` held high. `q` steps 4, 3, 2, 1 with `busy` = 1; `last` is high only while `q` = 1. `done` pulses once, in the 5th cycle after `start`, with `q` = 0.
- Stall and ignore: `load_val` = 3; drop `en` for 2 cycles while `q` = 2, and pulse `start` with `load_val` = 9 mid-run. `q` holds at 2 for 2 cycles, is unaffected by the second `start`, and `done` arrives 2 cycles later than in the unstalled case.
- Boundaries:
  - `load_val` = 0 gives a single `done` pulse, `busy` never high, `q` = 0.
  - `load_val` = 63 gives exactly 63 `busy` cycles and then `done`, with no wrap of `q`.
- Back-to-back: assert `start` with `load_val` = 2 during the `done` cycle of a prior run. `busy` rises in the next cycle with `q` = 2, and there is no IDLE cycle in between.
- Abort and reset mid-run:
  - `load_val` = 10, `abort` when `q` = 6: `busy` drops, `q` holds 6, no `done`.
  - Repeat the run with `clr` instead of `abort`: `q` = 0, `busy` = 0, no `done`.
